// File: rtl/ifetch_unit_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
// The master issues requests; the slave answers with ready and data.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// Multi-cycle fetch stage: owns the PC, fetches from variable-latency imem,
// holds one instruction until commit, then selects the next PC.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         rst_n,
    ifetch_unit_if.master imem,
    output logic [31:0]  Instruction,
    output logic         instr_valid,
    output logic [31:0]  PC_plus_4,
    input  logic         commit,
    input  logic         Branch,
    input  logic         nBranch,
    input  logic         Jmp,
    input  logic         Jal,
    input  logic         Jr,
    input  logic         Zero,
    input  logic [31:0]  Addr_Result,
    input  logic [31:0]  Read_data_1,
    output logic [31:0]  link_addr,
    output logic         fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID,
        S_FAULT
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        req_q;
    logic [31:0] link_q;
    logic        fault_q;

    logic [31:0] next_pc_d;
    logic [31:0] jmp_tgt;
    logic        take_br;

    assign PC_plus_4      = pc_q + 32'd4;
    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = req_q;
    assign Instruction    = instr_q;
    assign instr_valid    = valid_q;
    assign link_addr      = link_q;
    assign fetch_fault    = fault_q;

    // Conditions are made exclusive so Jr > jump > branch > sequential.
    always_comb begin
        jmp_tgt   = {PC_plus_4[31:28], instr_q[25:0], 2'b00};
        take_br   = (Branch & Zero) | (nBranch & ~Zero);
        next_pc_d = PC_plus_4;
        unique case (1'b1)
            Jr:
                next_pc_d = Read_data_1;
            (!Jr && (Jmp || Jal)):
                next_pc_d = jmp_tgt;
            (!Jr && !Jmp && !Jal && take_br):
                next_pc_d = Addr_Result;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            link_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (imem.imem_ready) begin
                        instr_q <= imem.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (commit) begin
                        valid_q <= 1'b0;
                        if (Jal) link_q <= PC_plus_4;
                        // A misaligned target parks the stage until reset.
                        if (next_pc_d[1:0] != 2'b00) begin
                            fault_q <= 1'b1;
                            state_q <= S_FAULT;
                        end else begin
                            pc_q    <= next_pc_d;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_FAULT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed-vector bench for ifetch_unit.
// Expected values are hand-computed constants.
module tb_ifetch_unit;

    logic        clock;
    logic        rst_n;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic [31:0] PC_plus_4;
    logic        commit;
    logic        Branch;
    logic        nBranch;
    logic        Jmp;
    logic        Jal;
    logic        Jr;
    logic        Zero;
    logic [31:0] Addr_Result;
    logic [31:0] Read_data_1;
    logic [31:0] link_addr;
    logic        fetch_fault;

    int n_cmp;
    int n_err;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .imem        (bus.master),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .PC_plus_4   (PC_plus_4),
        .commit      (commit),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Zero        (Zero),
        .Addr_Result (Addr_Result),
        .Read_data_1 (Read_data_1),
        .link_addr   (link_addr),
        .fetch_fault (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] w);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = w;
        tick();
        bus.imem_ready = 1'b0;
    endtask

    task automatic retire();
        commit = 1'b1;
        tick();
        commit  = 1'b0;
        Branch  = 1'b0;
        nBranch = 1'b0;
        Jmp     = 1'b0;
        Jal     = 1'b0;
        Jr      = 1'b0;
        Zero    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        commit = 1'b0;
        Branch = 1'b0;
        nBranch = 1'b0;
        Jmp = 1'b0;
        Jal = 1'b0;
        Jr = 1'b0;
        Zero = 1'b0;
        Addr_Result = '0;
        Read_data_1 = '0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;

        #3;
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_link", link_addr, 32'h0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_pc4", PC_plus_4, 32'h4);

        tick();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h2008_0005;
        rst_n = 1'b1;
        tick();
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_noval", {31'd0, instr_valid}, 32'd0);
        chk("ready_wo_req", Instruction, 32'h0);
        tick();
        bus.imem_ready = 1'b0;
        chk("cap_valid", {31'd0, instr_valid}, 32'd1);
        chk("cap_instr", Instruction, 32'h2008_0005);
        chk("cap_req_lo", {31'd0, bus.imem_req}, 32'd0);
        chk("cap_pc4", PC_plus_4, 32'h4);

        retire();
        chk("seq_addr", bus.imem_addr, 32'h4);
        chk("seq_req", {31'd0, bus.imem_req}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                commit = 1'b1;
                Jr = 1'b1;
                Read_data_1 = 32'h300;
            end
            tick();
            commit = 1'b0;
            Jr = 1'b0;
            chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
            chk("wait_addr", bus.imem_addr, 32'h4);
            chk("wait_noval", {31'd0, instr_valid}, 32'd0);
        end
        fetch(32'h1111_1111);
        chk("wait_cap", Instruction, 32'h1111_1111);

        Jr = 1'b1;
        Read_data_1 = 32'h10;
        retire();
        chk("jr_10", bus.imem_addr, 32'h10);

        fetch(32'h0);
        Branch = 1'b1;
        Zero = 1'b1;
        Addr_Result = 32'h40;
        retire();
        chk("br_taken", bus.imem_addr, 32'h40);

        fetch(32'h0);
        Jr = 1'b1;
        Read_data_1 = 32'h10;
        retire();
        fetch(32'h0);
        Branch = 1'b1;
        Zero = 1'b0;
        retire();
        chk("br_not", bus.imem_addr, 32'h14);

        fetch(32'h0);
        nBranch = 1'b1;
        Zero = 1'b0;
        retire();
        chk("nbr_taken", bus.imem_addr, 32'h40);

        fetch(32'h0);
        Jr = 1'b1;
        Read_data_1 = 32'h100;
        retire();
        fetch(32'h0C00_0020);
        Jal = 1'b1;
        retire();
        chk("jal_addr", bus.imem_addr, 32'h80);
        chk("jal_link", link_addr, 32'h104);

        fetch(32'h0800_0040);
        Jr = 1'b1;
        Jmp = 1'b1;
        Read_data_1 = 32'h200;
        retire();
        chk("jr_wins", bus.imem_addr, 32'h200);
        chk("link_hold", link_addr, 32'h104);

        fetch(32'h0);
        Jr = 1'b1;
        Read_data_1 = 32'hFFFF_FFFC;
        retire();
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("top_pc4", PC_plus_4, 32'h0);
        fetch(32'h0);
        retire();
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_nofault", {31'd0, fetch_fault}, 32'd0);

        fetch(32'hDEAD_BEEF);
        Jr = 1'b1;
        Read_data_1 = 32'h202;
        retire();
        chk("flt_flag", {31'd0, fetch_fault}, 32'd1);
        chk("flt_req", {31'd0, bus.imem_req}, 32'd0);
        chk("flt_noval", {31'd0, instr_valid}, 32'd0);
        chk("flt_pc", bus.imem_addr, 32'h0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h5555_5555;
        commit = 1'b1;
        tick();
        tick();
        commit = 1'b0;
        bus.imem_ready = 1'b0;
        chk("flt_stay_req", {31'd0, bus.imem_req}, 32'd0);
        chk("flt_stay", {31'd0, fetch_fault}, 32'd1);
        chk("flt_instr", Instruction, 32'hDEAD_BEEF);

        rst_n = 1'b0;
        #1;
        chk("rst_clr_flt", {31'd0, fetch_fault}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        fetch(32'h0);
        Jr = 1'b1;
        Read_data_1 = 32'h40;
        retire();
        chk("pre_rst_addr", bus.imem_addr, 32'h40);
        chk("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h7777_7777;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, bus.imem_req}, 32'd0);
        chk("async_addr", bus.imem_addr, 32'h0);
        tick();
        chk("discard", Instruction, 32'h0);
        chk("discard_val", {31'd0, instr_valid}, 32'd0);
        bus.imem_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
